// File: rtl/insn_fetch_if.sv
// Fetch-unit bus: byte memory port, redirect input and issue handshake to decode.
interface insn_fetch_if;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [31:0] insn;
  logic [9:0]  code;
  logic [31:0] pc_out;
  logic        insn_valid;
  logic        insn_ready;
  logic        illegal;

  // Fetch unit side.
  modport master (
    input  pc_in, pc_load, mem_rdata, mem_ack, insn_ready,
    output mem_addr, mem_req, insn, code, pc_out, insn_valid, illegal
  );

  // Environment side (core, memory and decoder).
  modport slave (
    output pc_in, pc_load, mem_rdata, mem_ack, insn_ready,
    input  mem_addr, mem_req, insn, code, pc_out, insn_valid, illegal
  );
endinterface

// File: rtl/insn_fetch_unit.sv
// Multi-cycle RV32I fetch: four byte reads assemble a word, classify opcode, issue.
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  insn_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  k;
  logic [31:0] insn_q;
  logic [9:0]  code_q;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic        illegal_q;
  logic [9:0]  class_c;
  logic        unused_pc_lsb;

  // One-hot opcode class; zero means illegal.
  function automatic logic [9:0] classify(input logic [6:0] op);
    logic [9:0] c;
    c = 10'b0;
    case (op)
      7'b0110111: c[0] = 1'b1;
      7'b0010111: c[1] = 1'b1;
      7'b1101111: c[2] = 1'b1;
      7'b1100111: c[3] = 1'b1;
      7'b1100011: c[4] = 1'b1;
      7'b0000011: c[5] = 1'b1;
      7'b0100011: c[6] = 1'b1;
      7'b0010011: c[7] = 1'b1;
      7'b0110011: c[8] = 1'b1;
      7'b1110011,
      7'b0001111: c[9] = 1'b1;
      default:    c    = 10'b0;
    endcase
    return c;
  endfunction

  // Opcode lives in byte 0, already captured by the time the last byte arrives.
  always_comb class_c = classify(insn_q[6:0]);

  // Redirect targets are word aligned; the low bits carry no information.
  assign unused_pc_lsb = ^bus.pc_in[1:0];

  // Memory request is decoded from state and registers only, never from mem_ack.
  assign bus.mem_req  = (state == FETCH);
  assign bus.mem_addr = pc + 32'(k);

  assign bus.insn       = insn_q;
  assign bus.code       = code_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.insn_valid = valid_q;
  assign bus.illegal    = illegal_q;

  // Fetch/issue state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      k         <= 2'd0;
      insn_q    <= 32'h0;
      code_q    <= 10'h0;
      pc_out_q  <= RESET_PC;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          k     <= 2'd0;
        end
        FETCH: begin
          if (bus.pc_load) begin
            // Redirect drops any byte acknowledged in the same cycle.
            pc    <= {bus.pc_in[31:2], 2'b00};
            k     <= 2'd0;
            state <= FETCH;
          end else if (bus.mem_ack) begin
            insn_q[{k, 3'b000} +: 8] <= bus.mem_rdata;
            if (k == 2'd3) begin
              state     <= ISSUE;
              valid_q   <= 1'b1;
              pc_out_q  <= pc;
              code_q    <= class_c;
              illegal_q <= (class_c == 10'b0);
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        ISSUE: begin
          if (bus.pc_load) begin
            // Redirect wins over accept; the issued instruction is consumed.
            pc      <= {bus.pc_in[31:2], 2'b00};
            k       <= 2'd0;
            state   <= FETCH;
            valid_q <= 1'b0;
          end else if (bus.insn_ready) begin
            pc      <= pc + 32'd4;
            k       <= 2'd0;
            state   <= FETCH;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Self-checking bench for insn_fetch_unit: directed scenarios plus random traffic.
module tb_insn_fetch_unit;

  logic clk;
  logic reset;
  insn_fetch_if bus_if ();

  insn_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 fetching, 2 presenting; nb = bytes received.
  int          phase;
  int          nb;
  logic [31:0] exp_pc;

  logic [6:0] class_op [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory image: fixed words at 0x0 and 0xFFFFFFFC, hashed words elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a == 32'h0) return 32'h0052_0463;
    if (a == 32'hFFFF_FFFC) return 32'hFFFF_FFFF;
    case (a[5:2])
      4'd0: op = 7'h37;  4'd1: op = 7'h17;  4'd2: op = 7'h6F;  4'd3: op = 7'h67;
      4'd4: op = 7'h63;  4'd5: op = 7'h03;  4'd6: op = 7'h23;  4'd7: op = 7'h13;
      4'd8: op = 7'h33;  4'd9: op = 7'h73;  4'd10: op = 7'h0F; 4'd11: op = 7'h7F;
      4'd12: op = 7'h00; 4'd13: op = 7'h5B; 4'd14: op = 7'h13; default: op = 7'h2B;
    endcase
    h = a * 32'h9E37_79B1;
    return {h[31:7], op};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return 8'(w >> {a[1:0], 3'b000});
  endfunction

  function automatic logic [9:0] exp_code(input logic [6:0] op);
    logic [9:0] c;
    c = 10'b0;
    for (int i = 0; i < 10; i++) if (op == class_op[i]) c[i] = 1'b1;
    if (op == 7'h0F) c[9] = 1'b1;
    return c;
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit a, input bit r, input bit ld, input logic [31:0] lpc);
    bit          ack_d;
    logic [31:0] w;
    if (phase == 1) begin
      check("mem_req_fetch", 32'(bus_if.mem_req), 32'd1);
      check("mem_addr", bus_if.mem_addr, exp_pc + 32'(nb));
      check("valid_fetch", 32'(bus_if.insn_valid), 32'd0);
    end else if (phase == 2) begin
      w = word_at(exp_pc);
      check("mem_req_issue", 32'(bus_if.mem_req), 32'd0);
      check("valid_issue", 32'(bus_if.insn_valid), 32'd1);
      check("insn", bus_if.insn, w);
      check("code", 32'(bus_if.code), 32'(exp_code(w[6:0])));
      check("illegal", 32'(bus_if.illegal), 32'(exp_code(w[6:0]) == 10'b0));
      check("pc_out", bus_if.pc_out, exp_pc);
    end else begin
      check("mem_req_idle", 32'(bus_if.mem_req), 32'd0);
      check("valid_idle", 32'(bus_if.insn_valid), 32'd0);
    end
    ack_d = a && bus_if.mem_req;
    bus_if.mem_ack    = ack_d;
    bus_if.mem_rdata  = ack_d ? byte_at(bus_if.mem_addr) : 8'($urandom);
    bus_if.insn_ready = r;
    bus_if.pc_load    = ld;
    bus_if.pc_in      = lpc;
    if (phase == 0) begin
      phase = 1;
      nb    = 0;
    end else if (ld) begin
      exp_pc = {lpc[31:2], 2'b00};
      nb     = 0;
      phase  = 1;
    end else if (phase == 1 && ack_d) begin
      nb++;
      if (nb == 4) phase = 2;
    end else if (phase == 2 && r) begin
      exp_pc = exp_pc + 32'd4;
      nb     = 0;
      phase  = 1;
    end
    @(negedge clk);
  endtask

  // Fetch until the model says an instruction is presented; wt idle cycles per byte.
  task automatic to_issue(input int wt);
    int w;
    w = 0;
    for (int i = 0; i < 400 && phase != 2; i++) begin
      if (w >= wt) begin
        step(1'b1, 1'b0, 1'b0, 32'h0);
        w = 0;
      end else begin
        step(1'b0, 1'b0, 1'b0, 32'h0);
        w++;
      end
    end
    check("to_issue_bound", 32'(phase), 32'd2);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"}, 32'(bus_if.mem_req), 32'd0);
    check({tag, "_valid"}, 32'(bus_if.insn_valid), 32'd0);
    check({tag, "_insn"}, bus_if.insn, 32'd0);
    check({tag, "_code"}, 32'(bus_if.code), 32'd0);
    check({tag, "_illegal"}, 32'(bus_if.illegal), 32'd0);
    check({tag, "_pc_out"}, bus_if.pc_out, 32'd0);
    check({tag, "_mem_addr"}, bus_if.mem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] lpc;
    reset             = 1'b1;
    bus_if.mem_ack    = 1'b0;
    bus_if.mem_rdata  = 8'h0;
    bus_if.insn_ready = 1'b0;
    bus_if.pc_load    = 1'b0;
    bus_if.pc_in      = 32'h0;
    phase  = 0;
    nb     = 0;
    exp_pc = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Basic fetch with zero-wait memory: valid on the 5th cycle after release.
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("basic_valid", 32'(bus_if.insn_valid), 32'd1);
    check("basic_insn", bus_if.insn, 32'h0052_0463);
    check("basic_code", 32'(bus_if.code), 32'b00_0001_0000);
    check("basic_pc_out", bus_if.pc_out, 32'h0);
    check("basic_illegal", 32'(bus_if.illegal), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Wait states and back-pressure.
    to_issue(3);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_next_addr", bus_if.mem_addr, 32'h8);

    // Redirect at byte 2 in the same cycle as an ack.
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    check("redir_addr", bus_if.mem_addr, 32'h100);
    check("redir_req", 32'(bus_if.mem_req), 32'd1);
    to_issue(0);
    check("redir_pc_out", bus_if.pc_out, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect and accept together.
    to_issue(1);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    check("collide_addr", bus_if.mem_addr, 32'h40);
    check("collide_valid", 32'(bus_if.insn_valid), 32'd0);

    // Illegal opcode at the top of the address space, then wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    to_issue(0);
    check("wrap_illegal", 32'(bus_if.illegal), 32'd1);
    check("wrap_code", 32'(bus_if.code), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", bus_if.mem_addr, 32'h0);

    // Asynchronous reset during byte 1 of a fetch.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("mid_req_before", 32'(bus_if.mem_req), 32'd1);
    check("mid_insn_before", 32'(bus_if.insn != 32'h0), 32'd1);
    bus_if.mem_ack = 1'b0;
    bus_if.pc_load = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset  = 1'b0;
    phase  = 0;
    nb     = 0;
    exp_pc = 32'h0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("restart_addr", bus_if.mem_addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      lpc = $urandom;
      if ($urandom_range(0, 3) == 0) lpc = 32'hFFFF_FFF0 | (lpc & 32'hF);
      step(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
           ($urandom_range(0, 31) == 0), lpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
